mem_arb: RTL and testbench
==========================

# mem_arb

Three-port round-robin arbiter that shares the CPU's single-port RAM between instruction fetch (port 0, driven by the control FSM), data load/store (port 1) and the debug/program loader (port 2). It latches one request at a time, drives the RAM `cs/we/oe` strobes for a fixed access latency, and returns a one-cycle completion pulse with read data to the winning port. It sits between the requesters and the RAM, replacing direct RAM strobe control by the control FSM.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width.
- `RAM_LAT`, 1, cycles from strobe assertion to valid `ram_rdata`; legal 1..4, anything else is an elaboration error.

- `clk` in 1, single clock, rising edge.
- `rst_n` in 1, reset; one clock, asynchronous, active-low.
- `req0`/`req1`/`req2` in 1, access request, level.
- `we0`/`we1`/`we2` in 1, 1 = write, 0 = read; valid with req.
- `addr0`/`addr1`/`addr2` in AW, word address; valid with req.
- `wdata0`/`wdata1`/`wdata2` in DW, write data; valid with req.
- `gnt0`/`gnt1`/`gnt2` out 1, one-cycle pulse: request accepted and latched.
- `done0`/`done1`/`done2` out 1, one-cycle pulse: access complete.
- `rdata` out DW, read data; shared, valid with the owning `doneN` on reads.
- `busy` out 1, high in ACC and DONE.
- `ram_cs`, `ram_we`, `ram_oe` out 1, RAM strobes.
- `ram_addr` out AW; `ram_wdata` out DW.
- `ram_rdata` in DW.

## Operation
- State machine: IDLE, ACC, DONE.
- IDLE:
  - Samples `req0..2` only in this state.
  - If any request is high, the winner is the first requesting port in order `ptr+1, ptr+2, ptr` (mod 3), where `ptr` is the last granted port.
  - Latch winner `addr`, `we`, `wdata` and port id; set `ptr` = winner; load `cnt` = RAM_LAT-1; go to ACC.
  - With no request, stay in IDLE.
- ACC:
  - `ram_cs` = 1, `ram_we` = latched we, `ram_oe` = ~latched we; `ram_addr`/`ram_wdata` come from the latch.
  - `gntN` is high in the first ACC cycle only.
  - When `cnt` == 0: on a read, capture `ram_rdata` into `rdata`, then go to DONE. Otherwise decrement `cnt`.
- DONE:
  - All strobes are 0; `doneN` of the latched port = 1; go to IDLE.
- Write completion leaves `rdata` holding its previous value.
- Requester rules:
  - Hold `req`/`addr`/`we`/`wdata` until `gntN`; after `gntN` they may change without effect.
  - Deassert `req` by the cycle after `doneN`, unless another access is wanted. A request still high in the following IDLE cycle is a new access.
- Requests on non-winning ports stay pending; they are not dropped.

## Timing
- Reset values: state IDLE, `ptr` = 2 (port 0 wins first), `cnt` = 0, `rdata` = 0, all `gnt`/`done`/`busy`/`ram_*` strobes = 0, `ram_addr`/`ram_wdata` = 0.
- Latency: request sampled in IDLE at edge k → ACC for cycles k+1..k+RAM_LAT → `doneN` in cycle k+RAM_LAT+1 → IDLE at k+RAM_LAT+2.
- Occupancy is RAM_LAT+2 cycles per access including IDLE; back-to-back throughput is one access per RAM_LAT+2 cycles.
- `ram_cs` stays high for exactly RAM_LAT consecutive cycles per access. Strobes are registered with no glitches between ACC cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. With all three held continuously, the grant sequence is 0,1,2,0,...
- Single persistent requester: granted every access; `ptr` is unchanged in effect.
- Reset asserted mid-ACC: strobes drop asynchronously and no `doneN` is issued. The access is lost and the requester must reissue after reset.
- Changing inputs on a port during its own ACC or DONE has no effect on the current access.

## Test plan
- Reset, then `req0` read at addr 0x10 with RAM word 0x00500093, RAM_LAT=2 → `gnt0` in cycle 1; `ram_cs`/`ram_oe` high in cycles 1–2; `done0` in cycle 3 with `rdata` = 0x00500093; `done1`/`done2` never high.
- `req1` write addr 0x20, data 0xDEADBEEF → `ram_we` = 1, `ram_oe` = 0 for 2 cycles with that addr/data; `done1` pulse; `rdata` keeps its previous value. A subsequent `req1` read returns 0xDEADBEEF.
- All three requests held continuously for 9 accesses → grant order 0,1,2,0,1,2,0,1,2; each `doneN` exactly RAM_LAT+1 cycles after its `gntN` cycle's IDLE sample.
- `req0` and `req2` asserted together right after a port-0 access → port 2 granted first, then port 0. `req0` stays pending and is not dropped.
- `rst_n` pulled low in the second ACC cycle of a read → `ram_cs` drops without a clock edge; no `done`; after release, `ptr` = 2 and a held `req0` is re-granted.
- RAM_LAT=4, port 1 read → `ram_cs` high exactly 4 cycles; `done1` 5 cycles after the sample edge; `rdata` equals `ram_rdata` from the last ACC cycle.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: three-port round-robin arbiter in front of a single-port RAM.
//
// Port 0 is instruction fetch, port 1 is data load/store, port 2 is the
// debug/program loader. One request is latched at a time. The RAM strobes are
// held for RAM_LAT cycles. The winning port then gets a one-cycle done pulse,
// and on reads the data is returned on the shared rdata bus.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN, weN, addrN, wdataN   per-port request (level), write enable, address, write data
//   gntN                       one-cycle pulse in the first access cycle (request latched)
//   doneN                      one-cycle pulse when the access completes
//   rdata                      read data, valid with the owning doneN on reads
//   busy                       high while an access is in flight (ACC and DONE)
//   ram_cs, ram_we, ram_oe     registered RAM strobes
//   ram_addr, ram_wdata        latched address / write data towards the RAM
//   ram_rdata                  RAM read data
module mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,

    input  logic          req2,
    input  logic          we2,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata2,

    output logic          gnt0,
    output logic          gnt1,
    output logic          gnt2,
    output logic          done0,
    output logic          done1,
    output logic          done2,
    output logic [DW-1:0] rdata,
    output logic          busy,

    output logic          ram_cs,
    output logic          ram_we,
    output logic          ram_oe,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_ram_lat
        $error("mem_arb: RAM_LAT must be in the range 1..4");
    end

    localparam logic [1:0] LatM1 = 2'(RAM_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    port_q, port_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    done_q, done_d;
    logic          cs_q, cs_d;
    logic          rwe_q, rwe_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;

    logic [2:0]    req_vec;
    logic [1:0]    win;
    logic          win_valid;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign req_vec = {req2, req1, req0};

    // Round-robin pick: search order is ptr+1, ptr+2, ptr (mod 3).
    always_comb begin
        win       = 2'd0;
        win_valid = |req_vec;
        case (ptr_q)
            2'd0:    win = req_vec[1] ? 2'd1 : (req_vec[2] ? 2'd2 : 2'd0);
            2'd1:    win = req_vec[2] ? 2'd2 : (req_vec[0] ? 2'd0 : 2'd1);
            default: win = req_vec[0] ? 2'd0 : (req_vec[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        case (win)
            2'd1: begin
                sel_we    = we1;
                sel_addr  = addr1;
                sel_wdata = wdata1;
            end
            2'd2: begin
                sel_we    = we2;
                sel_addr  = addr2;
                sel_wdata = wdata2;
            end
            default: begin
                sel_we    = we0;
                sel_addr  = addr0;
                sel_wdata = wdata0;
            end
        endcase
    end

    // Next-state logic. All outputs are computed one cycle ahead so that they
    // come straight from flops and cannot glitch between ACC cycles.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt_d   = 3'b000;
        done_d  = 3'b000;
        cs_d    = cs_q;
        rwe_d   = rwe_q;
        oe_d    = oe_q;
        busy_d  = busy_q;

        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StAcc;
                    ptr_d   = win;
                    port_d  = win;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    cnt_d   = LatM1;
                    gnt_d   = 3'b001 << win;
                    cs_d    = 1'b1;
                    rwe_d   = sel_we;
                    oe_d    = ~sel_we;
                    busy_d  = 1'b1;
                end
            end

            StAcc: begin
                if (cnt_q == 2'd0) begin
                    // ram_rdata is valid in the last ACC cycle only.
                    if (!we_q) begin
                        rdata_d = ram_rdata;
                    end
                    state_d = StDone;
                    cs_d    = 1'b0;
                    rwe_d   = 1'b0;
                    oe_d    = 1'b0;
                    done_d  = 3'b001 << port_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                cs_d    = 1'b0;
                rwe_d   = 1'b0;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ptr resets to 2 so that port 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 2'd2;
            cnt_q   <= 2'd0;
            port_q  <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            cs_q    <= 1'b0;
            rwe_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            rwe_q   <= rwe_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0      = gnt_q[0];
    assign gnt1      = gnt_q[1];
    assign gnt2      = gnt_q[2];
    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign done2     = done_q[2];
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign ram_cs    = cs_q;
    assign ram_we    = rwe_q;
    assign ram_oe    = oe_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb.
// Main instance uses RAM_LAT=2 against a RAM model that only drives valid data
// in the last strobe cycle; a second instance with RAM_LAT=4 covers the long latency.
module tb_mem_arb;
    localparam int LAT  = 2;
    localparam int LAT4 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (RAM_LAT = 2) ----------------
    logic [2:0]  req = '0;
    logic [2:0]  we  = '0;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic gnt0, gnt1, gnt2, done0, done1, done2, busy, ram_cs, ram_we, ram_oe;
    logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
    logic [2:0]  gnt_v, done_v;
    assign gnt_v  = {gnt2, gnt1, gnt0};
    assign done_v = {done2, done1, done0};

    mem_arb #(.AW(32), .DW(32), .RAM_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .req2(req[2]), .we2(we[2]), .addr2(addr[2]), .wdata2(wdata[2]),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
        .done0(done0), .done1(done1), .done2(done2),
        .rdata(rdata), .busy(busy),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'h0050_0093 : (32'h1234_0000 | 32'(i));
    endfunction

    // RAM model: data valid only when the strobe has been up for LAT cycles.
    logic [31:0] mem [64];
    int cs_run = 0;
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (ram_cs && ram_we && cs_run == LAT - 1) begin
            mem[ram_addr[5:0]] <= ram_wdata;
        end
        cs_run <= ram_cs ? cs_run + 1 : 0;
    end
    assign ram_rdata = (ram_cs && ram_oe && cs_run == LAT - 1) ? mem[ram_addr[5:0]]
                                                                : 32'hBAD0_BAD0;

    // ---------------- second DUT (RAM_LAT = 4), port 1 only ----------------
    logic req4 = 1'b0;
    logic g4_0, g4_1, g4_2, d4_0, d4_1, d4_2, busy4, cs4, we4, oe4;
    logic [31:0] rdata4, addr4, wdata4, rrd4;

    mem_arb #(.AW(32), .DW(32), .RAM_LAT(LAT4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(1'b0), .we0(1'b0), .addr0(32'h0), .wdata0(32'h0),
        .req1(req4), .we1(1'b0), .addr1(32'h44), .wdata1(32'h0),
        .req2(1'b0), .we2(1'b0), .addr2(32'h0), .wdata2(32'h0),
        .gnt0(g4_0), .gnt1(g4_1), .gnt2(g4_2),
        .done0(d4_0), .done1(d4_1), .done2(d4_2),
        .rdata(rdata4), .busy(busy4),
        .ram_cs(cs4), .ram_we(we4), .ram_oe(oe4),
        .ram_addr(addr4), .ram_wdata(wdata4), .ram_rdata(rrd4)
    );

    int cs4_run = 0;
    always @(posedge clk) cs4_run <= cs4 ? cs4_run + 1 : 0;
    assign rrd4 = (cs4 && oe4 && cs4_run == LAT4 - 1) ? (32'hCAFE_0000 ^ addr4) : 32'hBAD0_BAD0;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requester driver ----------------
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;
    cmd_t cq [3][$];

    task automatic push_cmd(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.w = w;
        c.a = a;
        c.d = d;
        cq[p].push_back(c);
    endtask

    // Holds each request until its grant, then immediately moves on to the next queued command.
    initial begin
        cmd_t c;
        for (int p = 0; p < 3; p++) begin
            addr[p]  = '0;
            wdata[p] = '0;
        end
        forever begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (req[p] && gnt_v[p]) req[p] = 1'b0;
                if (!req[p] && cq[p].size() > 0 && rst_n) begin
                    c        = cq[p].pop_front();
                    req[p]   = 1'b1;
                    we[p]    = c.w;
                    addr[p]  = c.a;
                    wdata[p] = c.d;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Works in whole accesses: a request sampled at edge k owns the RAM for
    // edges k..k+LAT+1; the next arbitration happens at edge k+LAT+2.
    typedef struct {
        int          port;
        bit          is_read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_exp;
        int          done_cyc;
    } exp_t;
    exp_t exp_q[$];
    int grant_log[$];
    int cyc = 0;
    int next_sample = 0;
    int last_port = 2;
    int cs_lo = -1;
    int cs_hi = -2;
    logic [2:0]  exp_gnt = '0;
    logic [31:0] ref_mem [64];
    logic [31:0] model_rdata = '0;

    function automatic int pick(input logic [2:0] r, input int last);
        for (int i = 1; i <= 3; i++) begin
            if (r[(last + i) % 3]) return (last + i) % 3;
        end
        return -1;
    endfunction

    initial begin
        int   w;
        exp_t it;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            cyc++;
            exp_gnt = '0;
            if (!rst_n) begin
                exp_q.delete();
                next_sample = 0;
                last_port   = 2;
                cs_lo       = -1;
                cs_hi       = -2;
                model_rdata = '0;
            end else if (cyc >= next_sample && req != 3'b000) begin
                w            = pick(req, last_port);
                last_port    = w;
                exp_gnt[w]   = 1'b1;
                it.port      = w;
                it.is_read   = !we[w];
                it.addr      = addr[w];
                it.wdata     = wdata[w];
                if (we[w]) ref_mem[addr[w][5:0]] = wdata[w];
                else       model_rdata = ref_mem[addr[w][5:0]];
                it.rdata_exp = model_rdata;
                it.done_cyc  = cyc + LAT;
                exp_q.push_back(it);
                grant_log.push_back(w);
                cs_lo       = cyc;
                cs_hi       = cyc + LAT - 1;
                next_sample = cyc + LAT + 2;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [2:0] exp_done;
        logic       in_acc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_ctrl", 64'({gnt_v, done_v, busy, ram_cs, ram_we, ram_oe}), 64'h0);
                check("reset_ram_addr", 64'(ram_addr), 64'h0);
                check("reset_ram_wdata", 64'(ram_wdata), 64'h0);
                check("reset_rdata", 64'(rdata), 64'h0);
            end else begin
                exp_done = 3'b000;
                if (exp_q.size() > 0 && exp_q[0].done_cyc == cyc) exp_done = 3'b001 << exp_q[0].port;
                in_acc = (cyc >= cs_lo) && (cyc <= cs_hi);
                check("gnt", 64'(gnt_v), 64'(exp_gnt));
                check("done", 64'(done_v), 64'(exp_done));
                check("ram_cs", 64'(ram_cs), 64'(in_acc));
                check("busy", 64'(busy), 64'(in_acc || exp_done != 3'b000));
                if (in_acc && exp_q.size() > 0) begin
                    check("ram_we", 64'(ram_we), 64'(!exp_q[0].is_read));
                    check("ram_oe", 64'(ram_oe), 64'(exp_q[0].is_read));
                    check("ram_addr", 64'(ram_addr), 64'(exp_q[0].addr));
                    if (!exp_q[0].is_read) check("ram_wdata", 64'(ram_wdata), 64'(exp_q[0].wdata));
                end
                if (exp_done != 3'b000) begin
                    check("rdata", 64'(rdata), 64'(exp_q[0].rdata_exp));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((req != 3'b000 || cq[0].size() != 0 || cq[1].size() != 0 || cq[2].size() != 0
                || exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles (limit %0d)", n, budget);
        end
    endtask

    task automatic check_grants(input string name, input int start, input int exp_seq[$]);
        check({name, "_count"}, 64'(grant_log.size() >= start + exp_seq.size()), 64'h1);
        if (grant_log.size() >= start + exp_seq.size()) begin
            for (int i = 0; i < exp_seq.size(); i++)
                check(name, 64'(grant_log[start + i]), 64'(exp_seq[i]));
        end
    endtask

    initial begin
        int lg;
        int n;
        int done_at;
        int gnt_at;
        logic [7:0]  cs_mask;
        logic        other_done;
        logic [31:0] rd4;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Read at 0x10 from port 0.
        push_cmd(0, 1'b0, 32'h10, 32'h0);
        wait_idle(50);
        check("read0_rdata", 64'(rdata), 64'h0050_0093);

        // Port 1 write then read back; the write leaves rdata alone.
        push_cmd(1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        wait_idle(50);
        check("write_keeps_rdata", 64'(rdata), 64'h0050_0093);
        push_cmd(1, 1'b0, 32'h20, 32'h0);
        wait_idle(50);
        check("readback_rdata", 64'(rdata), 64'hDEAD_BEEF);

        // Port 0 access, then ports 0 and 2 together: 2 must win, 0 stays pending.
        push_cmd(0, 1'b0, 32'h3, 32'h0);
        wait_idle(50);
        lg = grant_log.size();
        push_cmd(0, 1'b0, 32'h4, 32'h0);
        push_cmd(2, 1'b1, 32'h5, 32'h5555_AAAA);
        wait_idle(50);
        check_grants("pair_order", lg, '{2, 0});

        // Leave ptr at 2, then all three held for 9 accesses.
        push_cmd(2, 1'b0, 32'h5, 32'h0);
        wait_idle(50);
        lg = grant_log.size();
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 3; p++) push_cmd(p, k[0], 32'(8 + 3 * k + p), 32'(32'hA000 + 4 * k + p));
        wait_idle(200);
        check_grants("rr_order", lg, '{0, 1, 2, 0, 1, 2, 0, 1, 2});

        // Reset in the second ACC cycle of a port 1 read, with ports 0 and 2 waiting.
        push_cmd(1, 1'b0, 32'h6, 32'h0);
        n = 0;
        while (!gnt1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("gnt1_seen", 64'(gnt1), 64'h1);
        push_cmd(0, 1'b0, 32'h7, 32'h0);
        push_cmd(2, 1'b0, 32'h9, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_cs_drop", 64'({ram_cs, ram_oe, busy, done_v}), 64'h0);
        repeat (2) @(negedge clk);
        lg = grant_log.size();
        rst_n = 1'b1;
        wait_idle(50);
        check_grants("after_reset", lg, '{0, 2});

        // RAM_LAT=4 instance: port 1 read.
        @(negedge clk);
        req4 = 1'b1;
        @(posedge clk);
        cs_mask    = '0;
        done_at    = -1;
        gnt_at     = -1;
        other_done = 1'b0;
        rd4        = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (cs4) cs_mask[i-1] = 1'b1;
            if (g4_1 && gnt_at < 0) gnt_at = i;
            if (d4_1) begin
                done_at = i;
                rd4     = rdata4;
            end
            other_done = other_done | d4_0 | d4_2 | g4_0 | g4_2;
            if (g4_1) req4 = 1'b0;
        end
        check("lat4_gnt_cycle", 64'(gnt_at), 64'd1);
        check("lat4_cs_cycles", 64'(cs_mask), 64'h0F);
        check("lat4_done_cycle", 64'(done_at), 64'd5);
        check("lat4_rdata", 64'(rd4), 64'(32'hCAFE_0000 ^ 32'h44));
        check("lat4_other_ports", 64'(other_done), 64'h0);

        // Randomized traffic on all three ports.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (cq[p].size() < 2 && $urandom_range(0, 3) == 0)
                    push_cmd(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
            end
        end
        wait_idle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (limit 2000000)");
        $fatal(1, "watchdog expired");
    end

endmodule
